// File: rtl/q4_pkg.sv
// Shared types and constants for the Q4 result collector.
package q4_pkg;

    localparam logic [1:0] LEGAL_MAX = 2'd3;
    localparam int         RES_W     = 8;

    typedef logic [RES_W-1:0] q4_result_t;

    function automatic logic is_legal(input q4_result_t v);
        return v <= {{(RES_W-2){1'b0}}, LEGAL_MAX};
    endfunction

endpackage

// File: rtl/q4_result_collector_if.sv
// Valid/ready handshake bundle between the selector stage and the collector.
interface q4_result_collector_if;
    import q4_pkg::*;

    q4_result_t in_data;
    logic       in_valid;
    logic       in_ready;
    q4_result_t out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (output in_data, in_valid, out_ready,
                    input  in_ready, out_data, out_valid);
    modport slave  (input  in_data, in_valid, out_ready,
                    output in_ready, out_data, out_valid);
endinterface

// File: rtl/q4_fifo.sv
// Registered FIFO storage; count alone tells full from empty, flush empties it.
module q4_fifo
    import q4_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = RES_W
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wr_data,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    // Stale storage must never leak out while nothing is queued.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/q4_result_collector.sv
// Q4 result collector: handshake glue, sticky range check, optional hit histograms.
// Histograms are built only when Q4_HISTOGRAM_EN is defined.
module q4_result_collector
    import q4_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     flush,
    q4_result_collector_if.slave     bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     range_err,
    input  logic [1:0]               hist_sel,
    output logic [CNT_W-1:0]         hist_count
);
    logic full, empty, push, pop;
    logic range_err_q, range_err_d;

    // in_ready comes straight from full, so a pop never frees space in the same cycle.
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign push          = bus.in_valid && !full;
    assign pop           = !empty && bus.out_ready;

    q4_fifo #(.DEPTH(DEPTH), .W(RES_W)) u_fifo (
        .clk     (clk),
        .clear   (clear),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wr_data (bus.in_data),
        .rd_data (bus.out_data),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        range_err_d = range_err_q;
        if (flush)
            range_err_d = 1'b0;
        else if (push && !is_legal(bus.in_data))
            range_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) range_err_q <= 1'b0;
        else        range_err_q <= range_err_d;
    end

    assign range_err = range_err_q;

`ifdef Q4_HISTOGRAM_EN
    logic [CNT_W-1:0] hist_q [4];
    logic [CNT_W-1:0] hist_d [4];

    always_comb begin
        hist_d = hist_q;
        if (push && !flush && is_legal(bus.in_data)) begin
            if (hist_q[bus.in_data[1:0]] != '1)
                hist_d[bus.in_data[1:0]] = hist_q[bus.in_data[1:0]] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 4; i++) hist_q[i] <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign hist_count = hist_q[hist_sel];
`else
    logic hist_sel_unused;
    assign hist_sel_unused = ^hist_sel;
    assign hist_count      = '0;
`endif

endmodule

// File: tb/tb_q4_result_collector.sv
// Self-checking bench for q4_result_collector: queue-based reference model plus directed and random traffic.
module tb_q4_result_collector;
    import q4_pkg::*;

    localparam int DEPTH = 4;
`ifdef Q4_HISTOGRAM_EN
    localparam int CNT_W    = 2;
    localparam int EXP_HIST = 3;
`else
    localparam int CNT_W    = 8;
    localparam int EXP_HIST = 0;
`endif

    logic             clk = 1'b0;
    logic             clear;
    logic             flush;
    logic [1:0]       hist_sel;
    logic [2:0]       count;
    logic             range_err;
    logic [CNT_W-1:0] hist_count;

    q4_result_collector_if bus();

    q4_result_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .clear      (clear),
        .flush      (flush),
        .bus        (bus),
        .count      (count),
        .range_err  (range_err),
        .hist_sel   (hist_sel),
        .hist_count (hist_count)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: a plain queue of accepted bytes, a sticky flag, four counters.
    byte unsigned mq[$];
    bit           m_err;
    int           m_hist[4];

    always @(posedge clk or negedge clear) begin
        if (!clear) begin
            mq.delete();
            m_err = 1'b0;
            for (int i = 0; i < 4; i++) m_hist[i] = 0;
        end else begin
            bit do_push;
            bit do_pop;
            do_push = bus.in_valid && (mq.size() < DEPTH);
            do_pop  = (mq.size() > 0) && bus.out_ready;
            if (flush) begin
                mq.delete();
                m_err = 1'b0;
            end else begin
                if (do_pop) void'(mq.pop_front());
                if (do_push) begin
                    mq.push_back(bus.in_data);
                    if (bus.in_data > 8'd3) m_err = 1'b1;
                    else if (m_hist[bus.in_data] < (1 << CNT_W) - 1) m_hist[bus.in_data]++;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int exp_data;
        int exp_hist;
        exp_data = (mq.size() > 0) ? int'(mq[0]) : 0;
`ifdef Q4_HISTOGRAM_EN
        exp_hist = m_hist[hist_sel];
`else
        exp_hist = 0;
`endif
        chk("m_in_ready",  bus.in_ready,  mq.size() < DEPTH);
        chk("m_out_valid", bus.out_valid, mq.size() > 0);
        chk("m_out_data",  bus.out_data,  exp_data);
        chk("m_count",     count,         mq.size());
        chk("m_range_err", range_err,     m_err);
        chk("m_hist",      hist_count,    exp_hist);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
    endtask

    bit hold;

    initial begin
        idle_inputs();
        hist_sel = 2'd0;
        clear    = 1'b1;
        #2 clear = 1'b0;
        step();
        step();
        clear = 1'b1;
        step();
        step();

        // 1: reset idle values
        chk("t1_in_ready",  bus.in_ready,  1);
        chk("t1_out_valid", bus.out_valid, 0);
        chk("t1_count",     count,         0);
        chk("t1_range_err", range_err,     0);
        chk("t1_out_data",  bus.out_data,  0);

        // 2: fill 0..3, then drain in order
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i);
            step();
        end
        bus.in_valid = 1'b0;
        chk("t2_full_count", count,        4);
        chk("t2_in_ready",   bus.in_ready, 0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain_data", bus.out_data, i);
            step();
        end
        chk("t2_empty_valid", bus.out_valid, 0);
        bus.out_ready = 1'b0;

        // 3: full with simultaneous push/pop -> pop only, then push accepted
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(3 - i);
            step();
        end
        bus.in_data   = 8'd1;
        bus.out_ready = 1'b1;
        step();
        chk("t3_count_pop", count,        3);
        chk("t3_head",      bus.out_data, 2);
        chk("t3_in_ready",  bus.in_ready, 1);
        bus.out_ready = 1'b0;
        step();
        chk("t3_count_push", count, 4);
        bus.in_valid = 1'b0;
        flush        = 1'b1;
        step();
        flush = 1'b0;
        chk("t3_flush_count", count, 0);

        // 4: illegal value sets sticky flag, is stored intact, flush clears
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h14;
        step();
        bus.in_valid = 1'b0;
        chk("t4_range_err", range_err,    1);
        chk("t4_data",      bus.out_data, 8'h14);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("t4_popped_count", count,     0);
        chk("t4_err_sticky",   range_err, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd2;
        flush        = 1'b1;
        step();
        idle_inputs();
        chk("t4_flush_count", count,     0);
        chk("t4_flush_err",   range_err, 0);

        // 5: steady push+pop at occupancy 2, pointers wrap several times
        for (int i = 1; i <= 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i);
            step();
        end
        bus.out_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            bus.in_data = 8'(j % 4);
            chk("t5_count", count, 2);
            chk("t5_order", bus.out_data, (j < 2) ? j + 1 : (j - 2) % 4);
            step();
        end
        idle_inputs();
        flush = 1'b1;
        step();
        flush = 1'b0;

        // random traffic, honouring hold-until-accepted
        hold = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!hold) begin
                bus.in_valid = ($urandom_range(0, 99) < 60);
                bus.in_data  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
            end
            bus.out_ready = ($urandom_range(0, 99) < 50);
            flush         = ($urandom_range(0, 49) == 0);
            hist_sel      = 2'($urandom);
            hold          = bus.in_valid && !bus.in_ready && !flush;
            step();
        end
        idle_inputs();

        // 6: histogram saturation then asynchronous clear mid-stream
        clear = 1'b0;
        step();
        clear = 1'b1;
        step();
        hist_sel      = 2'd2;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'd2;
        for (int i = 0; i < 5; i++) step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        step();
        chk("t6_hist_sat", hist_count, EXP_HIST);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd1;
        step();
        step();
        @(posedge clk);
        #3 clear = 1'b0;
        #1;
        chk("t6_rst_count",     count,         0);
        chk("t6_rst_out_valid", bus.out_valid, 0);
        chk("t6_rst_in_ready",  bus.in_ready,  1);
        chk("t6_rst_out_data",  bus.out_data,  0);
        chk("t6_rst_hist",      hist_count,    0);
        idle_inputs();
        step();
        clear = 1'b1;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
